// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and widths for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam int RELOCK_W = 8;

endpackage

// File: rtl/sync_ff2.sv
// sync_ff2: two-flop synchroniser for a single asynchronous level
module sync_ff2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the async level through two flops; both clear on reset
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies lock, and gates the core reset
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 7425000,
    parameter int LOCK_STABLE_CYCLES  = 742500,
    parameter int RETRY_LIMIT         = 7,
    parameter int CNT_W               = 24
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                soft_rst_req,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic                fail,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int RW = $clog2(RETRY_LIMIT + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RET_MAX  = RW'(RETRY_LIMIT);

    state_t                nxt, state;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [RW-1:0]         retries, ret_nxt, ret_inc;
    logic [RELOCK_W-1:0]   rel_nxt;
    logic                  lock_s;

    sync_ff2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // state, counters and outputs; outputs decode the next state so they change with it
    always_ff @(posedge refclk or posedge rst)
        if (rst) begin
            state        <= S_PLLRST;
            cnt          <= '0;
            retries      <= '0;
            relock_count <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state        <= nxt;
            cnt          <= cnt_nxt;
            retries      <= ret_nxt;
            relock_count <= rel_nxt;
            pll_rst      <= nxt == S_PLLRST || nxt == S_FAIL;
            sys_rst      <= nxt != S_RUN;
            ready        <= nxt == S_RUN;
            fail         <= nxt == S_FAIL;
        end

    // next-state logic; soft_rst_req overrides every transition, including relock counting
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt + 1'b1;
        ret_nxt = retries;
        rel_nxt = relock_count;
        ret_inc = retries + 1'b1;
        case (state)
            S_PLLRST:
                if (cnt == RST_LAST) begin
                    nxt     = S_WAIT_LOCK;
                    cnt_nxt = '0;
                end
            S_WAIT_LOCK:
                if (lock_s) begin
                    nxt     = S_STABLE;
                    cnt_nxt = '0;
                end else if (cnt == TO_LAST) begin
                    ret_nxt = ret_inc;
                    nxt     = ret_inc == RET_MAX ? S_FAIL : S_PLLRST;
                    cnt_nxt = '0;
                end
            S_STABLE:
                if (!lock_s) begin
                    nxt     = S_WAIT_LOCK;
                    cnt_nxt = '0;
                end else if (cnt == ST_LAST) begin
                    nxt     = S_RUN;
                    ret_nxt = '0;
                    cnt_nxt = '0;
                end
            S_RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    nxt     = S_PLLRST;
                    rel_nxt = relock_count == '1 ? relock_count : relock_count + 1'b1;
                end
            end
            S_FAIL:
                cnt_nxt = '0;
            default: begin
                nxt     = S_PLLRST;
                cnt_nxt = '0;
            end
        endcase
        if (soft_rst_req) begin
            nxt     = S_PLLRST;
            cnt_nxt = '0;
            ret_nxt = '0;
            rel_nxt = relock_count;
        end
    end

endmodule
